// File: rtl/std_cache_pkg.sv
// Shared data-cache types and default geometry used by the tag/data arbiter.
package std_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC   = 8;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;
  localparam int unsigned DCACHE_LINE_WIDTH  = 128;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]  tag;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic                         valid;
    logic                         dirty;
  } cache_line_t;

  typedef struct packed {
    logic [(DCACHE_TAG_WIDTH+7)/8-1:0] tag;
    logic [DCACHE_LINE_WIDTH/8-1:0]    data;
    logic [DCACHE_SET_ASSOC-1:0]       vldrty;
  } cl_be_t;

endpackage

// File: rtl/dcache_rr_tag_arb_rr_arb_onehot.sv
// Round-robin one-hot arbiter over ports FIRST..N-1; owns the pointer state.
module rr_arb_onehot #(
  parameter int unsigned N     = 4,
  parameter int unsigned FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         hold,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NRR = N - FIRST;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] ptr_next;
  logic          found;
  int unsigned   idx;

  // Search from the pointer upwards, wrapping inside the round-robin range.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NRR; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - NRR;
      if (!hold && !found && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        found         = 1'b1;
        win           = PW'(idx);
      end
    end
  end

  // Next pointer is the port after the winner, wrapping to FIRST.
  always_comb begin
    ptr_next = ptr;
    if (win == PW'(N-1)) ptr_next = PW'(FIRST);
    else                 ptr_next = win + 1'b1;
  end

  // Pointer moves only when a round-robin port actually won.
  always_ff @(posedge clk) begin
    if (rst)        ptr <= PW'(FIRST);
    else if (found) ptr <= ptr_next;
  end

endmodule

// File: rtl/dcache_rr_tag_arb.sv
// Data-cache tag/data SRAM arbiter: optional port-0 priority, round-robin for
// the rest, one-cycle read return with hit detection against the late tag.
module dcache_rr_tag_arb
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS    = 4,
  parameter int unsigned SET_ASSOC   = DCACHE_SET_ASSOC,
  parameter int unsigned INDEX_WIDTH = DCACHE_INDEX_WIDTH,
  parameter int unsigned TAG_WIDTH   = DCACHE_TAG_WIDTH,
  parameter int unsigned LINE_WIDTH  = DCACHE_LINE_WIDTH,
  parameter bit          PRIO_PORT0  = 1'b1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]    req_i,
  input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]    tag_i,
  input  logic [NR_PORTS-1:0]                   we_i,
  input  cache_line_t [NR_PORTS-1:0]            wdata_i,
  input  cl_be_t [NR_PORTS-1:0]                 be_i,
  output logic [NR_PORTS-1:0]                   gnt_o,
  output logic [NR_PORTS-1:0]                   rvalid_o,
  output cache_line_t [SET_ASSOC-1:0]           rdata_o,
  output logic [SET_ASSOC-1:0]                  hit_way_o,
  output logic                                  multi_hit_o,
  output logic [SET_ASSOC-1:0]                  req_o,
  output logic [INDEX_WIDTH-1:0]                addr_o,
  output logic                                  we_o,
  output cache_line_t                           wdata_o,
  output cl_be_t                                be_o,
  input  cache_line_t [SET_ASSOC-1:0]           rdata_i
);

  localparam int unsigned FIRST = PRIO_PORT0 ? 1 : 0;
  localparam int unsigned PW    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic [NR_PORTS-1:0] port_req;
  logic [NR_PORTS-1:0] rr_gnt;
  logic [NR_PORTS-1:0] gnt;
  logic                prio_win;
  logic                any_gnt;
  logic [PW-1:0]       win;
  logic [PW-1:0]       win_q;
  logic                pending;
  logic [SET_ASSOC-1:0] hit;

  // A port requests when any of its way lines is raised.
  always_comb begin
    port_req = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) port_req[p] = |req_i[p];
  end

  assign prio_win = PRIO_PORT0 && port_req[0];

  rr_arb_onehot #(
    .N     (NR_PORTS),
    .FIRST (FIRST)
  ) u_arb (
    .clk  (clk_i),
    .rst  (rst_i),
    .req  (port_req),
    .hold (prio_win),
    .gnt  (rr_gnt)
  );

  // Final grant: port 0 overrides the round-robin result; encode the winner.
  always_comb begin
    gnt = rr_gnt;
    if (prio_win) begin
      gnt    = '0;
      gnt[0] = 1'b1;
    end
    win = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++)
      if (gnt[p]) win = PW'(p);
    any_gnt = |gnt;
  end

  assign gnt_o = gnt;

  // SRAM-side request mux; everything is zero when nobody is granted.
  always_comb begin
    req_o   = '0;
    addr_o  = '0;
    we_o    = 1'b0;
    wdata_o = '0;
    be_o    = '0;
    if (any_gnt) begin
      req_o   = req_i[win];
      addr_o  = addr_i[win];
      we_o    = we_i[win];
      wdata_o = wdata_i[win];
      be_o    = be_i[win];
    end
  end

  // Remember a granted read so its data and hit vector return next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending <= 1'b0;
      win_q   <= '0;
    end else begin
      pending <= any_gnt && !we_i[win];
      win_q   <= win;
    end
  end

  // Read return: one-hot valid, tag compare against the winner's late tag.
  always_comb begin
    rvalid_o = '0;
    hit      = '0;
    if (pending) begin
      rvalid_o[win_q] = 1'b1;
      for (int unsigned w = 0; w < SET_ASSOC; w++)
        hit[w] = rdata_i[w].valid && (rdata_i[w].tag == tag_i[win_q]);
    end
  end

  assign rdata_o     = rdata_i;
  assign hit_way_o   = hit;
  assign multi_hit_o = pending && (|(hit & (hit - 1'b1)));

endmodule

// File: doc/dcache_rr_tag_arb.md
DCACHE_RR_TAG_ARB -- requirements
Module: dcache_rr_tag_arb

Interface
REQ-001 Parameter NR_PORTS, default 4: number of requesters; port 0 is the miss handler.
REQ-002 Parameter SET_ASSOC, default 8: number of ways; each way has one SRAM request line.
REQ-003 Parameter INDEX_WIDTH, default 12: byte-index address width.
REQ-004 Parameter TAG_WIDTH, default 44: tag width.
REQ-005 Parameter LINE_WIDTH, default 128: data bits per cache line.
REQ-006 Parameter PRIO_PORT0, default 1: when 1, port 0 always wins; when 0, all ports join round-robin.
REQ-007 clk_i  in  1  clock; all state updates on the rising edge.
REQ-008 rst_i  in  1  reset, synchronous and active-high.
REQ-009 req_i  in  NR_PORTS x SET_ASSOC  per-port, per-way request.
REQ-010 addr_i  in  NR_PORTS x INDEX_WIDTH  set index per port.
REQ-011 tag_i  in  NR_PORTS x TAG_WIDTH  late tag, valid the cycle after that port's grant.
REQ-012 we_i, wdata_i, be_i  in  per port  write enable, line (tag, data, valid, dirty) and byte enables.
REQ-013 gnt_o  out  NR_PORTS  combinational grant, same cycle as the request.
REQ-014 rvalid_o  out  NR_PORTS  one-hot read-data valid, one cycle after a granted read.
REQ-015 rdata_o  out  SET_ASSOC lines  registered-source read data, broadcast to all ports.
REQ-016 hit_way_o  out  SET_ASSOC  one-hot-or-zero hit vector for the rvalid port.
REQ-017 multi_hit_o  out  1  more than one way matched.
REQ-018 req_o, addr_o, we_o, wdata_o, be_o  out  SRAM-side muxed request.
REQ-019 rdata_i  in  SET_ASSOC lines  SRAM read data, one-cycle latency.

Function
REQ-020 At most one port is granted per cycle; gnt_o is one-hot or zero.
REQ-021 A port is requesting when the OR of its req_i ways is 1.
REQ-022 With PRIO_PORT0=1, a requesting port 0 is always granted; ports 1..NR_PORTS-1 are round-robin among themselves.
REQ-023 The round-robin pointer advances to the port after the winner, but only on cycles where a round-robin port was granted.
REQ-024 The pointer wraps from NR_PORTS-1 to the first round-robin port.
REQ-025 The pointer holds when nothing is granted or when port 0 wins.
REQ-026 req_o, addr_o, we_o, wdata_o and be_o are the winner's inputs; req_o is 0 when nothing is granted.
REQ-027 For a granted read (we_i=0), register the winner index and a pending flag.
REQ-028 In the next cycle, raise rvalid_o for that port only and pass rdata_i to rdata_o.
REQ-029 A granted write produces no rvalid_o.
REQ-030 hit_way_o[w] = rdata_i[w].valid AND (rdata_i[w].tag == tag_i[winner_q]), qualified by the pending flag.
REQ-031 hit_way_o is all zero when no read is pending.
REQ-032 multi_hit_o = pending AND popcount(hit_way_o) > 1.
REQ-033 Back-to-back grants are allowed: a new grant in cycle N+1 is independent of completing the read from cycle N.
REQ-034 A port that drops its request without a grant loses nothing; no state is held for it.

Reset
REQ-035 While rst_i=1, the round-robin pointer resets to the first round-robin port (1 if PRIO_PORT0, else 0).
REQ-036 While rst_i=1, the pending flag clears, and rvalid_o, hit_way_o and multi_hit_o read 0 in the following cycle.
REQ-037 A read granted in the same cycle as rst_i=1 is discarded; no rvalid_o follows it.
REQ-038 gnt_o stays combinational during reset; the SRAM may still be accessed.

Structure
REQ-039 The cache_line_t and cl_be_t typedefs come from std_cache_pkg; no new package types are introduced.
REQ-040 Default parameter values are taken from the existing DCACHE_* constants in std_cache_pkg.
REQ-041 One sub-module, rr_arb_onehot: a parametrised round-robin one-hot arbiter holding the pointer state.

Verification
REQ-042 Reset, then ports 1, 2, 3 all request continuously (PRIO_PORT0=1) -> grants are 1,2,3,1,2,3 with one grant per cycle.
REQ-043 Port 0 and port 2 request together while the pointer is at 2 -> port 0 granted; the pointer stays at 2; next cycle port 2 is granted.
REQ-044 Port 1 reads index 5; next cycle way 3 returns valid=1 with a matching tag -> rvalid_o=0010, hit_way_o=00001000, multi_hit_o=0.
REQ-045 Ways 1 and 6 both valid with a matching tag -> hit_way_o=01000010, multi_hit_o=1.
REQ-046 Port 3 write granted -> the SRAM sees we_o=1 with port 3's wdata and be; the next cycle has rvalid_o=0 and hit_way_o=0.
REQ-047 rst_i asserted in the grant cycle of a port 2 read -> no rvalid_o next cycle; the pointer returns to 1.
